bank_host_seq: RTL and testbench
================================

BANK_HOST_SEQ -- requirements
Module: bank_host_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the bank data word.
REQ-002 SHALL have parameter ADDR_W, default 4, width of the word-line address.
REQ-003 SHALL have parameter WR_CYC, default 2, number of w_drv_in-high cycles per write (legal range 1..15).
REQ-004 SHALL have parameter TMO, default 8, the cycle limit for waiting on a bank phase.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-006 Ports, one per line:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  1  host request valid
  req_ready  out  1  sequencer can accept a request
  req_we  in  1  1 = write, 0 = read
  req_addr  in  ADDR_W  word-line address
  req_wdata  in  DATA_W  write data
  rsp_valid  out  1  response valid
  rsp_ready  in  1  host accepts the response
  rsp_rdata  out  DATA_W  read data (0 for writes)
  rsp_err  out  1  bank phase timeout
  w_en  out  1  write request to the bank controller
  wl_addr  out  ADDR_W  latched address to the bank
  wdata  out  DATA_W  latched write data to the bank
  preb_in  in  1  bank precharge-bar (0 = PRE phase)
  w_drv_in  in  1  bank write-driver enable
  sa_en_in  in  1  bank sense-amp enable
  sa_dout  in  DATA_W  sense-amp data output

Function
REQ-007 SHALL implement FSM states IDLE, WR, WR_REC, RD_PRE, RD_SNS, RSP.
REQ-008 IDLE: req_ready=1; on req_valid&req_ready, latch req_addr/req_wdata/req_we into wl_addr/wdata/op; go to WR if we, else RD_PRE.
REQ-009 req_ready SHALL be 0 in every state other than IDLE.
REQ-010 wl_addr and wdata SHALL hold their latched values from accept until the next accept.
REQ-011 WR: w_en=1; a counter increments on each cycle with w_drv_in=1; when the count reaches WR_CYC, deassert w_en the following cycle and go to WR_REC.
REQ-012 WR_REC: w_en=0; on the first cycle with preb_in=0, go to RSP with rsp_rdata=0.
REQ-013 RD_PRE: w_en=0; wait for preb_in=0 observed after accept, then go to RD_SNS.
  - An in-flight sense started before accept SHALL NOT be captured.
REQ-014 RD_SNS: on the first cycle with sa_en_in=1, register sa_dout into rsp_rdata and go to RSP.
REQ-015 RSP: rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE.
  - Minimum latency: accept to rsp_valid is 3 cycles for a read with the bank in PRE at accept.
REQ-016 In WR, WR_REC, RD_PRE and RD_SNS, a wait-cycle counter SHALL run.
  - If the counter reaches TMO without the awaited event: w_en=0, rsp_err=1, rsp_rdata=0, go to RSP.
  - The counter clears on every state change.
REQ-017 rsp_err SHALL clear on the response handshake.
REQ-018 w_en SHALL be 1 only in state WR.
REQ-019 A req_valid received while busy SHALL be ignored (not latched).
REQ-020 A new request SHALL be accepted no earlier than the cycle after the rsp handshake.

Reset
REQ-021 On rst_n=0, outputs SHALL immediately take: state IDLE, w_en=0, req_ready=1 (after release), rsp_valid=0, rsp_err=0, rsp_rdata=0, wl_addr=0, wdata=0, counters=0.
REQ-022 Reset mid-operation SHALL abort the transaction with no response issued; w_en drops asynchronously.

Structure
REQ-023 State encodings (one-hot, 6 bits) and the parameter defaults SHALL reside in shared package bank_pkg, reused by the bank controller.
REQ-024 The timeout counter SHALL be a sub-module bank_tmo_cnt (inputs clr, en; output expired; parameter TMO).

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
  - Write: addr=0x3, wdata=0xA5, WR_CYC=2, bank model responding normally -> w_en high exactly 3 cycles, wl_addr=0x3, wdata=0xA5, then rsp_valid with rsp_rdata=0, rsp_err=0.
  - Read: addr=0x7, sa_dout=0x5C when sa_en_in=1 -> rsp_rdata=0x5C, rsp_err=0, w_en never high.
  - Read accepted during bank SENSE2 (sa_en_in=1 in the accept cycle, sa_dout=0xFF) -> 0xFF ignored; the next sense value 0x12 is returned.
  - Timeout: bank model holds preb_in=1 in RD_PRE -> rsp_valid with rsp_err=1 after TMO=8 wait cycles, rsp_rdata=0.
  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable; req_ready=0 throughout; a req_valid pulse in that window is dropped.
  - Reset asserted in WR -> w_en=0 immediately, no rsp_valid; after release, a read completes normally.

Source files
------------

// File: rtl/bank_pkg.sv
// ---------------------------------------------------------------------------
// bank_pkg
// Shared definitions for the bank host sequencer and the bank controller:
// default parameter values, the one-hot sequencer state encoding and a
// helper that identifies the states in which a bank phase is being awaited.
// ---------------------------------------------------------------------------
package bank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int WR_CYC_DEF = 2;
  localparam int TMO_DEF    = 8;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    WR     = 6'b000010,
    WR_REC = 6'b000100,
    RD_PRE = 6'b001000,
    RD_SNS = 6'b010000,
    RSP    = 6'b100000
  } seq_state_e;

  // States in which the sequencer waits on the bank and the timeout runs.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == WR) || (s == WR_REC) || (s == RD_PRE) || (s == RD_SNS);
  endfunction

endpackage

// File: rtl/bank_tmo_cnt.sv
// ---------------------------------------------------------------------------
// bank_tmo_cnt
// Wait-cycle counter for bank phases. Counts cycles while en=1 and clr=0;
// expired is high during the TMO-th consecutive enabled cycle, so the owner
// can give up at the end of that cycle.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous clear (takes priority over counting)
//   en       count enable (a wait state is active)
//   expired  this is the TMO-th wait cycle without the awaited event
// ---------------------------------------------------------------------------
module bank_tmo_cnt
  import bank_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);

  logic [CW-1:0] cnt;

  // The owner asserts clr whenever it leaves a wait state or times out, so
  // cnt never passes LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/bank_host_seq.sv
// ---------------------------------------------------------------------------
// bank_host_seq
// Host-side sequencer for one memory bank. Accepts one read or write
// request at a time, walks the bank through its write or precharge/sense
// phases and returns a single response. Every bank phase is guarded by a
// timeout that produces an error response.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           host request handshake
//   req_we, req_addr, req_wdata   request fields (latched on accept)
//   rsp_valid/rsp_ready           host response handshake
//   rsp_rdata, rsp_err            read data (0 for writes/timeouts), timeout flag
//   w_en, wl_addr, wdata          write request, latched address/data to bank
//   preb_in, w_drv_in, sa_en_in   bank phase indicators
//   sa_dout                       sense-amp data
// ---------------------------------------------------------------------------
module bank_host_seq
  import bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WR_CYC = WR_CYC_DEF,
  parameter int TMO    = TMO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              w_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              preb_in,
  input  logic              w_drv_in,
  input  logic              sa_en_in,
  input  logic [DATA_W-1:0] sa_dout
);

  localparam logic [3:0] WR_LAST = 4'(WR_CYC);

  seq_state_e state;
  logic       op_we;
  logic [3:0] wr_cnt;
  logic [3:0] wr_cnt_inc;
  logic       evt;
  logic       wait_st;
  logic       tmo_clr;
  logic       tmo_expired;

  // evt is the event the current wait state is waiting for. In WR it fires
  // on the drive cycle that brings the count up to WR_CYC.
  always_comb begin
    wr_cnt_inc = wr_cnt + 4'd1;
    evt        = 1'b0;
    case (state)
      WR:             evt = w_drv_in && (wr_cnt_inc == WR_LAST);
      WR_REC, RD_PRE: evt = !preb_in;
      RD_SNS:         evt = sa_en_in;
      default:        evt = 1'b0;
    endcase
  end

  assign wait_st = is_wait_state(state);

  // Clearing on every exit from a wait state makes the counter start from
  // zero on each entry, including WR -> WR_REC and RD_PRE -> RD_SNS.
  assign tmo_clr = !wait_st || evt || tmo_expired;

  bank_tmo_cnt #(
    .TMO(TMO)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (wait_st),
    .expired(tmo_expired)
  );

  // Main sequencer. A phase event that lands in the same cycle as the
  // timeout wins, because the awaited event did arrive in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      w_en      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wl_addr   <= '0;
      wdata     <= '0;
      op_we     <= 1'b0;
      wr_cnt    <= '0;
    end else if (wait_st && !evt && tmo_expired) begin
      state     <= RSP;
      w_en      <= 1'b0;
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wl_addr   <= req_addr;
            wdata     <= req_wdata;
            op_we     <= req_we;
            wr_cnt    <= '0;
            req_ready <= 1'b0;
            if (req_we) begin
              state <= WR;
              w_en  <= 1'b1;
            end else begin
              state <= RD_PRE;
            end
          end
        end
        WR: begin
          if (w_drv_in) begin
            wr_cnt <= wr_cnt_inc;
          end
          if (evt) begin
            state <= WR_REC;
            w_en  <= 1'b0;
          end
        end
        WR_REC: begin
          if (evt) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        RD_PRE: begin
          // Only precharge seen after accept counts, so a sense already in
          // flight at accept time is never captured.
          if (evt) begin
            state <= RD_SNS;
          end
        end
        RD_SNS: begin
          if (evt) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= op_we ? '0 : sa_dout;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          w_en      <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_host_seq.sv
// ---------------------------------------------------------------------------
// tb_bank_host_seq
// Self-checking bench for bank_host_seq. Bank inputs for each transaction
// come from a per-cycle schedule (index 0 = accept cycle). A reference
// model scans that schedule with the phase/timeout rules to predict the
// response cycle, error flag, read data and number of w_en cycles.
// ---------------------------------------------------------------------------
module tb_bank_host_seq;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int WR_CYC = 2;
  localparam int TMO    = 8;
  localparam int NCYC   = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              w_en;
  logic [ADDR_W-1:0] wl_addr;
  logic [DATA_W-1:0] wdata;
  logic              preb_in = 1'b1;
  logic              w_drv_in = 1'b0;
  logic              sa_en_in = 1'b0;
  logic [DATA_W-1:0] sa_dout = '0;

  always #5 clk = ~clk;

  bank_host_seq #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .WR_CYC(WR_CYC),
    .TMO   (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .w_en     (w_en),
    .wl_addr  (wl_addr),
    .wdata    (wdata),
    .preb_in  (preb_in),
    .w_drv_in (w_drv_in),
    .sa_en_in (sa_en_in),
    .sa_dout  (sa_dout)
  );

  int checks = 0;
  int errors = 0;

  bit                preb_s [NCYC];
  bit                drv_s  [NCYC];
  bit                saen_s [NCYC];
  logic [DATA_W-1:0] sad_s  [NCYC];

  int                exp_lat;
  int                exp_wen;
  logic              exp_err;
  logic [DATA_W-1:0] exp_rdata;

  int                obs_lat;
  int                obs_wen;
  logic              obs_err;
  logic [DATA_W-1:0] obs_rdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleBank;
    for (int i = 0; i < NCYC; i++) begin
      preb_s[i] = 1'b1;
      drv_s[i]  = 1'b0;
      saen_s[i] = 1'b0;
      sad_s[i]  = '0;
    end
  endtask

  task automatic driveBank(input int c);
    preb_in  = preb_s[c];
    w_drv_in = drv_s[c];
    sa_en_in = saen_s[c];
    sa_dout  = sad_s[c];
  endtask

  // First cycle in [from, from+TMO-1] carrying the event (kind 0: preb low,
  // kind 1: sense enable); -1 when the phase times out.
  function automatic int scanFor(input int kind, input int from);
    for (int i = from; i < from + TMO; i++) begin
      if (kind == 0 && !preb_s[i]) return i;
      if (kind == 1 && saen_s[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: exp_lat is the cycle (counted from the accept edge) in
  // which rsp_valid first shows; cycle 1 is the first cycle after accept.
  task automatic modelTxn(input bit we);
    int c;
    int hit;
    int cnt;
    exp_err   = 1'b0;
    exp_rdata = '0;
    exp_wen   = 0;
    c         = 1;
    if (we) begin
      cnt = 0;
      hit = -1;
      for (int i = c; i < c + TMO; i++) begin
        if (drv_s[i]) cnt++;
        if (cnt == WR_CYC) begin
          hit = i;
          break;
        end
      end
      if (hit < 0) begin
        exp_err = 1'b1;
        exp_wen = TMO;
        exp_lat = c + TMO;
        return;
      end
      exp_wen = hit - c + 1;
      c       = hit + 1;
      hit     = scanFor(0, c);
      if (hit < 0) begin
        exp_err = 1'b1;
        exp_lat = c + TMO;
      end else begin
        exp_lat = hit + 1;
      end
    end else begin
      hit = scanFor(0, c);
      if (hit < 0) begin
        exp_err = 1'b1;
        exp_lat = c + TMO;
        return;
      end
      c   = hit + 1;
      hit = scanFor(1, c);
      if (hit < 0) begin
        exp_err = 1'b1;
        exp_lat = c + TMO;
      end else begin
        exp_rdata = sad_s[hit];
        exp_lat   = hit + 1;
      end
    end
  endtask

  // One full transaction: accept, wait for the response while injecting
  // stray requests, hold the response for `hold` cycles, then handshake.
  task automatic applyStimulus(input string name, input bit we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input int hold);
    int busy_ready;
    int unstable;
    modelTxn(we);
    obs_lat    = -1;
    obs_wen    = 0;
    busy_ready = 0;
    unstable   = 0;
    checkOutput({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    driveBank(0);
    tick;
    for (int c = 1; c < NCYC; c++) begin
      driveBank(c);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ADDR_W'($urandom);
      req_wdata = DATA_W'($urandom);
      if (c == 1) begin
        checkOutput({name, ".wl_addr_latched"}, 32'(wl_addr), 32'(addr));
        checkOutput({name, ".wdata_latched"}, 32'(wdata), 32'(data));
      end
      if (rsp_valid) begin
        obs_lat = c;
        break;
      end
      if (req_ready) busy_ready++;
      if (w_en) obs_wen++;
      tick;
    end
    obs_err   = rsp_err;
    obs_rdata = rsp_rdata;
    checkOutput({name, ".latency"}, 32'(obs_lat), 32'(exp_lat));
    checkOutput({name, ".w_en_cycles"}, 32'(obs_wen), 32'(exp_wen));
    checkOutput({name, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
    checkOutput({name, ".rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    checkOutput({name, ".w_en_in_rsp"}, 32'(w_en), 32'd0);
    checkOutput({name, ".req_ready_busy"}, 32'(busy_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_addr  = ~addr;
      tick;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
          req_ready !== 1'b0 || wl_addr !== addr || wdata !== data)
        unstable++;
    end
    checkOutput({name, ".hold_stable"}, 32'(unstable), 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checkOutput({name, ".rsp_valid_cleared"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, ".rsp_err_cleared"}, 32'(rsp_err), 32'd0);
    checkOutput({name, ".req_ready_after"}, 32'(req_ready), 32'd1);
    checkOutput({name, ".wl_addr_kept"}, 32'(wl_addr), 32'(addr));
  endtask

  initial begin
    int resp_seen;

    // Reset state while rst_n is held low.
    idleBank;
    driveBank(0);
    #1;
    checkOutput("reset.w_en", 32'(w_en), 32'd0);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset.rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset.wl_addr", 32'(wl_addr), 32'd0);
    checkOutput("reset.wdata", 32'(wdata), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    checkOutput("reset.req_ready_after_release", 32'(req_ready), 32'd1);

    // Directed write: bank raises the write driver one cycle behind w_en.
    idleBank;
    drv_s[2] = 1'b1;
    drv_s[3] = 1'b1;
    for (int i = 5; i < NCYC; i++) preb_s[i] = 1'b0;
    applyStimulus("wr_dir", 1'b1, 4'h3, 8'hA5, 0);
    checkOutput("wr_dir.w_en_exact", 32'(obs_wen), 32'd3);
    checkOutput("wr_dir.rdata_zero", 32'(obs_rdata), 32'd0);
    checkOutput("wr_dir.err_zero", 32'(obs_err), 32'd0);

    // Directed read: bank in PRE right after accept, sense on the next cycle.
    idleBank;
    for (int i = 1; i < NCYC; i++) preb_s[i] = 1'b0;
    saen_s[2] = 1'b1;
    sad_s[2]  = 8'h5C;
    applyStimulus("rd_dir", 1'b0, 4'h7, 8'h00, 0);
    checkOutput("rd_dir.rdata", 32'(obs_rdata), 32'h5C);
    checkOutput("rd_dir.min_latency", 32'(obs_lat), 32'd3);
    checkOutput("rd_dir.no_w_en", 32'(obs_wen), 32'd0);

    // Read accepted while a sense is already in flight.
    idleBank;
    saen_s[0] = 1'b1;
    sad_s[0]  = 8'hFF;
    saen_s[1] = 1'b1;
    sad_s[1]  = 8'hFF;
    for (int i = 2; i < NCYC; i++) preb_s[i] = 1'b0;
    saen_s[3] = 1'b1;
    sad_s[3]  = 8'h12;
    applyStimulus("rd_inflight", 1'b0, 4'h9, 8'h00, 0);
    checkOutput("rd_inflight.rdata", 32'(obs_rdata), 32'h12);

    // Timeout: precharge never arrives.
    idleBank;
    applyStimulus("rd_tmo", 1'b0, 4'h2, 8'h00, 0);
    checkOutput("rd_tmo.err", 32'(obs_err), 32'd1);
    checkOutput("rd_tmo.latency", 32'(obs_lat), 32'(TMO + 1));
    checkOutput("rd_tmo.rdata", 32'(obs_rdata), 32'd0);

    // Backpressure: response held 5 cycles with a stray request pulse.
    idleBank;
    for (int i = 1; i < NCYC; i++) preb_s[i] = 1'b0;
    saen_s[3] = 1'b1;
    sad_s[3]  = 8'h6B;
    applyStimulus("bp", 1'b0, 4'hC, 8'h3E, 5);
    tick;
    checkOutput("bp.no_stray_accept", 32'(req_ready), 32'd1);

    // Reset in the middle of a write.
    idleBank;
    driveBank(0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'h5;
    req_wdata = 8'h77;
    tick;
    req_valid = 1'b0;
    checkOutput("rst_wr.w_en_before", 32'(w_en), 32'd1);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr.w_en_async", 32'(w_en), 32'd0);
    checkOutput("rst_wr.wl_addr", 32'(wl_addr), 32'd0);
    tick;
    rst_n = 1'b1;
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (rsp_valid) resp_seen++;
    end
    checkOutput("rst_wr.no_response", 32'(resp_seen), 32'd0);
    idleBank;
    for (int i = 1; i < NCYC; i++) preb_s[i] = 1'b0;
    saen_s[2] = 1'b1;
    sad_s[2]  = 8'hC3;
    applyStimulus("rst_wr.read_after", 1'b0, 4'h1, 8'h00, 1);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NCYC; i++) begin
        preb_s[i] = ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1;
        drv_s[i]  = ($urandom_range(0, 99) < 50);
        saen_s[i] = ($urandom_range(0, 99) < 35);
        sad_s[i]  = DATA_W'($urandom);
      end
      applyStimulus($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
                    DATA_W'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
